mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one slow_memory port (128-bit line, 28-bit line address) between the I-cache and D-cache miss/write-back interfaces inside CHIP.
- Each cache keeps its existing slow-memory handshake. The arbiter serialises their transactions and forwards the granted transaction's signals downstream.
- Keeps per-requester completed-transaction counters for performance reporting.

Parameters:
- ADDR_W, 28, line address width (address bits 31:4).
- DATA_W, 128, line data width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with D above I.
- CNT_W, 16, width of the saturating transaction counters.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_read, i_write  input  1 each  I-cache request
- i_addr  input  ADDR_W  I-cache line address
- i_wdata  input  DATA_W  I-cache write data
- i_rdata  output  DATA_W  read data to I-cache
- i_ready  output  1  completion to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as the i_* ports, for the D-cache
- mem_read, mem_write  output  1 each  to slow memory
- mem_addr  output  ADDR_W  to slow memory
- mem_wdata  output  DATA_W  to slow memory
- mem_rdata  input  DATA_W  from slow memory
- mem_ready  input  1  from slow memory
- cnt_i, cnt_d  output  CNT_W each  completed transactions per requester
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. Reset values:
  - state = IDLE; RR pointer = I (D wins the first tie).
  - mem_read, mem_write, mem_addr, mem_wdata = 0.
  - cnt_i, cnt_d = 0; i_ready, d_ready = 0; busy = 0.
- Request definition: req_x = x_read | x_write.
- Requester contract: hold the request and its address/data stable until x_ready; deassert in the cycle after x_ready.
- FSM states: IDLE, GNT_I, GNT_D, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests:
    - ARB_MODE=1: D wins.
    - ARB_MODE=0: the requester not granted last wins.
  - On the grant edge, register the winner's read/write/addr/wdata into the mem_* outputs. mem_read/mem_write are therefore high one cycle after the request is first seen in IDLE.
- Read and write both asserted: write wins; mem_read is forced to 0.
- GNT_x:
  - mem_* outputs hold the latched values, independent of later requester changes.
  - A requester dropping its request early is illegal; the arbiter still completes the transaction.
  - On a cycle with mem_ready=1:
    - x_ready = 1 combinationally, in the same cycle, for the granted side only.
    - x_rdata carries mem_rdata.
    - The next edge moves to RELEASE, clears mem_read/mem_write, increments cnt_x, and sets the RR pointer to x.
- RELEASE: exactly one cycle with mem_read = mem_write = 0, giving slow memory its idle gap. Then IDLE.
- Back-to-back requests: minimum spacing between the ready of one transaction and mem_read/write of the next is 2 idle cycles (RELEASE, IDLE).
- i_rdata/d_rdata equal mem_rdata whenever their ready is high. Their value is otherwise don't-care; the implementation drives mem_rdata to both.
- mem_ready in IDLE or RELEASE is ignored: no ready output, no counter change.
- The non-granted requester never sees ready. Its request stays pending and is arbitrated in the next IDLE.
- Counters saturate at all-ones and do not wrap.
- Reset mid-transaction: immediate return to the reset values. No ready is issued for the aborted transaction; slow memory is reset by the system.
- No combinational path from any requester input to any mem_* output.

Test Plan:
- Lone I read, i_addr=28'h0000010, memory latency 4:
  - mem_read=1 and mem_addr=28'h0000010 one cycle after the request.
  - i_ready pulses exactly 1 cycle, with i_rdata = memory line.
  - cnt_i=1; mem_read low for at least 1 cycle afterwards.
- Lone D write, d_addr=28'h0000020, d_wdata=128'hA5…A5:
  - mem_write=1 with matching addr/wdata and mem_read=0.
  - d_ready pulses once; cnt_d=1; i_ready stays 0 throughout.
- ARB_MODE=0, I and D both request continuously for 6 transactions:
  - Grants go D,I,D,I,D,I.
  - cnt_i=cnt_d=3; never both ready in one cycle.
- ARB_MODE=1, same stimulus:
  - D served first.
  - I served only when D deasserts; I completes after D's stream ends.
- mem_ready forced high for 3 cycles while IDLE:
  - No ready pulses; counters unchanged; state stays IDLE.
- rst_n low for 1 cycle while in GNT_D mid-latency:
  - All outputs 0 asynchronously; d_ready never pulses; cnt_d unchanged at 0.
  - A fresh D request after reset completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares a single slow_memory port between the I-cache and the D-cache.
//   Each cache keeps its usual slow-memory handshake (hold read/write,
//   address and data until ready). The arbiter grants one cache at a time,
//   latches that cache's request into the mem_* outputs, forwards the memory
//   completion back to the granted cache only, and then inserts one idle
//   cycle before the next grant. Per-cache saturating counters record how
//   many transactions each side has completed.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_read, i_write            I-cache request strobes
//   i_addr, i_wdata            I-cache line address / write line
//   i_rdata, i_ready           read line / completion back to the I-cache
//   d_read ... d_ready         same set for the D-cache
//   mem_read, mem_write        registered request strobes to slow memory
//   mem_addr, mem_wdata        registered line address / write line
//   mem_rdata, mem_ready       read line / completion from slow memory
//   cnt_i, cnt_d               completed transactions per cache (saturating)
//   busy                       high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_d,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             FIXED_PRIO = (ARB_MODE != 0);

  state_t state;
  state_t state_nxt;

  logic req_i;
  logic req_d;
  logic pick_i;
  logic pick_d;
  logic last_d;
  logic done_i;
  logic done_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // Arbitration decision, only meaningful while IDLE. last_d is the
  // round-robin pointer: it remembers whether D was the last side served,
  // so on a tie the other side wins. It resets to "I served last" so that
  // D wins the very first tie. In fixed-priority mode D simply always wins.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (req_d && (!req_i || FIXED_PRIO || !last_d)) begin
      pick_d = 1'b1;
    end else if (req_i) begin
      pick_i = 1'b1;
    end
  end

  // A transaction completes on the cycle memory answers while that side
  // holds the grant. mem_ready in IDLE/RELEASE never reaches a cache.
  assign done_i = (state == GNT_I) && mem_ready;
  assign done_d = (state == GNT_D) && mem_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RELEASE is an unconditional single idle cycle so
  // slow memory always sees its strobes drop before the next request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = GNT_D;
        end else if (pick_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          state_nxt = RELEASE;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Downstream request register. The winner's request is captured on the
  // grant edge and then held for the whole transaction, so nothing a cache
  // does after the grant (including dropping its request early) can disturb
  // memory, and there is no combinational path from a cache to memory.
  // When read and write are both asserted the write takes precedence.
  // Strobes clear on the completion edge; address/data are simply left
  // in place because memory ignores them while the strobes are low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            mem_read  <= d_read & ~d_write;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (pick_i) begin
            mem_read  <= i_read & ~i_write;
            mem_write <= i_write;
            mem_addr  <= i_addr;
            mem_wdata <= i_wdata;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer and completion counters. Both update on the
  // completion edge of a transaction; counters stick at all-ones rather
  // than wrapping so long runs still report a meaningful lower bound.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
      cnt_i  <= '0;
      cnt_d  <= '0;
    end else begin
      if (done_i) begin
        last_d <= 1'b0;
        if (cnt_i != CNT_MAX) begin
          cnt_i <= cnt_i + CNT_ONE;
        end
      end
      if (done_d) begin
        last_d <= 1'b1;
        if (cnt_d != CNT_MAX) begin
          cnt_d <= cnt_d + CNT_ONE;
        end
      end
    end
  end

  // Completion is passed straight through in the same cycle, to the
  // granted side only. Read data goes to both caches; each one only
  // looks at it while its own ready is high.
  assign i_ready = done_i;
  assign d_ready = done_d;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign busy    = (state != IDLE);

endmodule
